// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared declarations for the bit-serial adder slice:
//   DEFAULT_WIDTH - operand/sum width used when no override is given
//   state_t       - controller states (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Operand and result handshakes of the bit-serial adder.
//   A, B, Cin, in_valid / in_ready   : operand channel (master -> slave)
//   Sum, Carry, out_valid / out_ready : result channel  (slave -> master)
// Modports:
//   master - the producer/consumer around the adder
//   slave  - the adder itself
// -----------------------------------------------------------------------------
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output A, B, Cin, in_valid, out_ready,
        input  in_ready, Sum, Carry, out_valid
    );

    modport slave (
        input  A, B, Cin, in_valid, out_ready,
        output in_ready, Sum, Carry, out_valid
    );

endinterface : serial_adder_if

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// Single-bit half-adder cell.
//   a_i, b_i : input bits
//   s_o      : sum bit   (a_i ^ b_i)
//   c_o      : carry bit (a_i & b_i)
// -----------------------------------------------------------------------------
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule : half_adder

// File: rtl/serial_adder_full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Combinational one-bit full adder made of two half-adder cells and an OR.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;    // propagate: a ^ b
    logic g;    // generate:  a & b
    logic t;    // carry propagated through from cin

    half_adder u_ha0 (.a_i(a), .b_i(b),   .s_o(p), .c_o(g));
    half_adder u_ha1 (.a_i(p), .b_i(cin), .s_o(s), .c_o(t));

    // g and t are never both 1, so OR equals the full-adder majority carry.
    assign cout = g | t;

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial ripple adder: one full-adder cell reused LSB-first over WIDTH
// cycles. Operands arrive on a valid/ready handshake, the result (Sum and
// carry-out) leaves on another.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if slave (A, B, Cin, in_valid/in_ready,
//          Sum, Carry, out_valid/out_ready)
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic fa_s;
    logic fa_cout;

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                // in_ready is 1 whenever the flops are out of reset in IDLE,
                // so in_valid alone marks the acceptance edge here.
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.Cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // New sum bit enters at the MSB so that after WIDTH shifts
                // the first (LSB) result bit has reached position 0.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.Sum       = sum_q;
    assign bus.Carry     = carry_q;

endmodule : serial_adder
